conv_window_gen: RTL
====================

Name: conv_window_gen

Overview:
- Raster-scan 3x3 window generator that feeds the convolution kernel stage.
- Accepts one pixel per valid cycle, in row-major order.
- Holds the two previous image rows in line buffers.
- Emits the flattened 72-bit 3x3 neighbourhood, plus centre coordinates, for every interior pixel ("valid" convolution, no padding).

Parameters:
- IMG_W, 256, pixels per row (≥3).
- IMG_H, 256, rows per frame (≥3).
- PIX_W, 8, bits per pixel.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  in_pixel is accepted this cycle.
- in_pixel  in  PIX_W  raster pixel.
- in_sof  in  1  start of frame; qualified by in_valid.
- win_valid  out  1  window/win_row/win_col hold a new window this cycle (single-cycle pulse).
- window  out  9*PIX_W  flattened 3x3 window.
- win_row  out  $clog2(IMG_H)  centre row of window.
- win_col  out  $clog2(IMG_W)  centre column of window.
- frame_done  out  1  pulses together with the last window of a frame.

Behaviour:
- Reset: clk, asynchronous active-high rst.
  - All outputs reset to 0: win_valid, window, win_row, win_col, frame_done.
  - Row/col counters reset to 0 and the column shift registers to 0.
  - Line-buffer storage is not reset.
- Pixel accept: only on cycles with in_valid=1; idle cycles hold all state.
  - in_valid gaps of any length are legal.
  - There is no backpressure.
- Position tracking: counters (r,c) give the position of the pixel being accepted.
  - After each accept, c increments; at c=IMG_W-1, c wraps to 0 and r increments.
  - At (IMG_H-1, IMG_W-1), both wrap to 0.
- in_sof: in_valid&&in_sof forces the accepted pixel to position (0,0), whatever the counters hold.
  - Counters continue from (0,1).
  - A partial frame in progress is abandoned; no frame_done is issued for it.
- Line buffers:
  - LB1 holds row r-1 and LB0 holds row r-2, each IMG_W deep, indexed by c.
  - On accept at column c: read LB1[c] and LB0[c] (read-before-write), write LB0[c]←LB1[c] and LB1[c]←in_pixel.
  - Stale contents from the previous frame are never emitted, because emission requires r≥2.
- Column shift: a 3-column register holds the last three accepted columns of rows r-2, r-1 and r.
- Window packing: index k = 3*i + j, where i=0 is the top row (r-2) and j=0 is the left column (c-2).
  - Pixel k occupies window[PIX_W*k +: PIX_W].
  - So window[PIX_W-1:0] = P(r-2,c-2) and the top slice = P(r,c), i.e. the current pixel.
- Emission: on the accept of P(r,c) with r≥2 and c≥2:
  - In the next cycle (latency 1), win_valid=1, win_row=r-1, win_col=c-1, and window is as above.
  - In all other cycles win_valid=0; window, win_row and win_col hold their last values.
- Column 0/1 of each row: the shift register restarts; windows never straddle a row wrap.
- Per frame: exactly (IMG_W-2)*(IMG_H-2) windows.
- frame_done=1 in the same cycle as the window with win_row=IMG_H-2 and win_col=IMG_W-2.
- Back-to-back frames: the first pixel of the next frame may be accepted the cycle after the last pixel of the previous one, with no bubble required.
- Reset mid-frame: the next accepted pixel is (0,0).
  - No window is emitted until row 2 of the new frame, even if in_sof is absent.

Decomposition:
- Shared package conv_pkg holds:
  - PIX_W and the derived WIN_W = 9*PIX_W.
  - Tap-index constants TAP_TL=0 … TAP_BR=8, per the packing above.
  - The default IMG_W/IMG_H.
- Sub-module line_buffer: one IMG_W×PIX_W single-clock memory with read-before-write at a shared address; instantiated twice.
- Counters, shift registers and output registers live in conv_window_gen.

Test Plan (IMG_W=8, IMG_H=6 unless stated; pixel value P(r,c)=(8r+c) mod 256):
1. Continuous frame, in_sof on the first pixel:
   - The first win_valid comes one cycle after accepting P(2,2)=18, with win_row=1, win_col=1.
   - window slices k0..k8 are 0,1,2,8,9,10,16,17,18.
   - 24 windows in total; frame_done with the window centred at (4,6), whose k8=P(5,7)=47.
2. Random in_valid gaps (≈50% duty):
   - Window contents and count are identical to scenario 1.
   - win_valid never asserts on a cycle that does not follow an accept.
3. Two back-to-back frames, second frame pixels +100:
   - 48 windows and two frame_done pulses.
   - The first window of frame 2 has k0=100 and k8=118; no window mixes frames.
4. in_sof re-asserted at frame-1 position (3,4):
   - No frame_done for the abandoned frame.
   - The next window is centred at (1,1) and carries the new frame's data.
5. rst asserted mid-row at (3,5), then released and the stream resumed without in_sof:
   - All outputs read 0 immediately.
   - Stimulus restarted at position (0,0) yields the scenario-1 sequence exactly.
6. Default parameters (256×256) with a ramp image:
   - 64516 windows.
   - The last window has win_row=254, win_col=254 and k8=P(255,255).

Source files
------------

// File: rtl/conv_pkg.sv
// Shared constants for the 3x3 raster window generator.
//   PIX_W            default bits per pixel
//   WIN_W            bits in a flattened 3x3 window at the default PIX_W
//   IMG_W/H_DEF      default frame geometry
//   TAP_*            slice index k = 3*i + j of each tap in the flattened window,
//                    i = 0 is the oldest row (r-2), j = 0 is the oldest column (c-2)
package conv_pkg;

    localparam int unsigned PIX_W     = 8;
    localparam int unsigned WIN_W     = 9 * PIX_W;

    localparam int unsigned IMG_W_DEF = 256;
    localparam int unsigned IMG_H_DEF = 256;

    localparam int unsigned TAP_TL = 0;
    localparam int unsigned TAP_TC = 1;
    localparam int unsigned TAP_TR = 2;
    localparam int unsigned TAP_ML = 3;
    localparam int unsigned TAP_MC = 4;
    localparam int unsigned TAP_MR = 5;
    localparam int unsigned TAP_BL = 6;
    localparam int unsigned TAP_BC = 7;
    localparam int unsigned TAP_BR = 8;

endpackage

// File: rtl/conv_window_gen_line_buffer.sv
// One image row of pixel storage, single clock.
// Read is combinational from i_addr, write lands on the clock edge, so a read and a write at
// the same address in one cycle return the old contents (read-before-write).
// Contents are deliberately not reset.
//   clk      system clock
//   i_we     write enable
//   i_addr   column index, shared by read and write
//   i_wdata  pixel to store
//   o_rdata  pixel currently stored at i_addr
module line_buffer #(
    parameter int unsigned DEPTH = 256,
    parameter int unsigned PIX_W = 8
) (
    input  logic                     clk,
    input  logic                     i_we,
    input  logic [$clog2(DEPTH)-1:0] i_addr,
    input  logic [PIX_W-1:0]         i_wdata,
    output logic [PIX_W-1:0]         o_rdata
);

    logic [PIX_W-1:0] r_mem [DEPTH];

    assign o_rdata = r_mem[i_addr];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

endmodule

// File: rtl/conv_window_gen.sv
// Raster-scan 3x3 window generator ("valid" convolution, no padding).
// Accepts one pixel per in_valid cycle in row-major order and, one cycle after accepting
// pixel (r,c) with r>=2 and c>=2, presents the 3x3 neighbourhood centred on (r-1,c-1).
//   clk, rst     clock and asynchronous active-high reset
//   in_valid     accept in_pixel this cycle
//   in_pixel     raster pixel
//   in_sof       start of frame, forces the accepted pixel to (0,0)
//   win_valid    single-cycle pulse: window/win_row/win_col are new
//   window       flattened window, tap k at [PIX_W*k +: PIX_W], k = 3*row + col
//   win_row/col  centre coordinates of the window
//   frame_done   pulses with the last window of a frame
module conv_window_gen #(
    parameter int unsigned IMG_W = conv_pkg::IMG_W_DEF,
    parameter int unsigned IMG_H = conv_pkg::IMG_H_DEF,
    parameter int unsigned PIX_W = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic [PIX_W-1:0]         in_pixel,
    input  logic                     in_sof,
    output logic                     win_valid,
    output logic [9*PIX_W-1:0]       window,
    output logic [$clog2(IMG_H)-1:0] win_row,
    output logic [$clog2(IMG_W)-1:0] win_col,
    output logic                     frame_done
);

    import conv_pkg::*;

    localparam int unsigned CW       = $clog2(IMG_W);
    localparam int unsigned RW       = $clog2(IMG_H);
    localparam int unsigned WIN_BITS = 9 * PIX_W;

    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

    // Position of the next pixel to be accepted
    logic [RW-1:0] r_row;
    logic [CW-1:0] r_col;

    // Position of the pixel on the input this cycle (in_sof overrides the counters)
    logic [RW-1:0] w_row;
    logic [CW-1:0] w_col;
    logic [RW-1:0] w_row_nxt;
    logic [CW-1:0] w_col_nxt;

    // Line buffer read data: LB0 holds row r-2, LB1 holds row r-1
    logic [PIX_W-1:0] w_lb0_rd;
    logic [PIX_W-1:0] w_lb1_rd;

    // Columns c-1 (c1) and c-2 (c2) of rows r-2 (top), r-1 (mid), r (bot)
    logic [PIX_W-1:0] r_c1_top, r_c1_mid, r_c1_bot;
    logic [PIX_W-1:0] r_c2_top, r_c2_mid, r_c2_bot;

    logic [WIN_BITS-1:0] w_window;
    logic                w_emit;
    logic                w_last;

    logic                r_win_valid;
    logic [WIN_BITS-1:0] r_window;
    logic [RW-1:0]       r_win_row;
    logic [CW-1:0]       r_win_col;
    logic                r_frame_done;

    always_comb begin
        w_row = in_sof ? '0 : r_row;
        w_col = in_sof ? '0 : r_col;

        if (w_col == COL_LAST) begin
            w_col_nxt = '0;
            w_row_nxt = (w_row == ROW_LAST) ? '0 : w_row + RW'(1);
        end else begin
            w_col_nxt = w_col + CW'(1);
            w_row_nxt = w_row;
        end

        // Row >= 2 guarantees both line buffers hold rows of this frame
        w_emit = in_valid && (w_row >= RW'(2)) && (w_col >= CW'(2));
        w_last = (w_row == ROW_LAST) && (w_col == COL_LAST);
    end

    always_comb begin
        w_window = '0;
        w_window[PIX_W*TAP_TL +: PIX_W] = r_c2_top;
        w_window[PIX_W*TAP_TC +: PIX_W] = r_c1_top;
        w_window[PIX_W*TAP_TR +: PIX_W] = w_lb0_rd;
        w_window[PIX_W*TAP_ML +: PIX_W] = r_c2_mid;
        w_window[PIX_W*TAP_MC +: PIX_W] = r_c1_mid;
        w_window[PIX_W*TAP_MR +: PIX_W] = w_lb1_rd;
        w_window[PIX_W*TAP_BL +: PIX_W] = r_c2_bot;
        w_window[PIX_W*TAP_BC +: PIX_W] = r_c1_bot;
        w_window[PIX_W*TAP_BR +: PIX_W] = in_pixel;
    end

    // Row r-1 moves down into LB0 as the current pixel replaces it in LB1
    line_buffer #(
        .DEPTH (IMG_W),
        .PIX_W (PIX_W)
    ) u_lb1 (
        .clk     (clk),
        .i_we    (in_valid),
        .i_addr  (w_col),
        .i_wdata (in_pixel),
        .o_rdata (w_lb1_rd)
    );

    line_buffer #(
        .DEPTH (IMG_W),
        .PIX_W (PIX_W)
    ) u_lb0 (
        .clk     (clk),
        .i_we    (in_valid),
        .i_addr  (w_col),
        .i_wdata (w_lb1_rd),
        .o_rdata (w_lb0_rd)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_row        <= '0;
            r_col        <= '0;
            r_c1_top     <= '0;
            r_c1_mid     <= '0;
            r_c1_bot     <= '0;
            r_c2_top     <= '0;
            r_c2_mid     <= '0;
            r_c2_bot     <= '0;
            r_win_valid  <= 1'b0;
            r_window     <= '0;
            r_win_row    <= '0;
            r_win_col    <= '0;
            r_frame_done <= 1'b0;
        end else if (in_valid) begin
            r_row        <= w_row_nxt;
            r_col        <= w_col_nxt;
            // Columns 0/1 of a row refill the shift stages before the first emission at c=2,
            // so leftovers from the previous row never reach a window.
            r_c2_top     <= r_c1_top;
            r_c2_mid     <= r_c1_mid;
            r_c2_bot     <= r_c1_bot;
            r_c1_top     <= w_lb0_rd;
            r_c1_mid     <= w_lb1_rd;
            r_c1_bot     <= in_pixel;
            r_win_valid  <= w_emit;
            r_frame_done <= w_emit && w_last;
            if (w_emit) begin
                r_window  <= w_window;
                r_win_row <= w_row - RW'(1);
                r_win_col <= w_col - CW'(1);
            end
        end else begin
            r_win_valid  <= 1'b0;
            r_frame_done <= 1'b0;
        end
    end

    assign win_valid  = r_win_valid;
    assign window     = r_window;
    assign win_row    = r_win_row;
    assign win_col    = r_win_col;
    assign frame_done = r_frame_done;

endmodule
